// File: rtl/cnt_down_timer.sv
// Programmable countdown timer: loads a clamped value, decrements once per
// prescaled tick, and flags expiry with a one-cycle done pulse and a level.
module cnt_down_timer #(
  parameter int TICK_DIV = 100,
  parameter int MAX_VAL  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] out,
  output logic       busy,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [6:0]  MAX_LAST  = 7'(MAX_VAL);

  function automatic logic [6:0] clamp_load(input logic [6:0] v);
    return (v > MAX_LAST) ? MAX_LAST : v;
  endfunction

  function automatic logic [6:0] sat_dec(input logic [6:0] v);
    return (v > 7'd1) ? (v - 7'd1) : 7'd0;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [6:0]  out_q, out_d;
  logic        done_q, done_d;
  logic        busy_q, expired_q;
  logic        tick;

  assign tick = (state_q == S_RUN) && (presc_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    if (load) begin
      out_d   = clamp_load(load_val);
      state_d = S_IDLE;
      presc_d = 16'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          presc_d = 16'd0;
          if (!pause && start && (out_q != 7'd0)) state_d = S_RUN;
        end
        S_RUN: begin
          // pause beats a coincident tick, so the prescaler holds at its last value
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            presc_d = 16'd0;
            out_d   = sat_dec(out_q);
            if (out_q <= 7'd1) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        S_PAUSE: begin
          if (!pause && start) state_d = S_RUN;
        end
        S_DONE: begin
          out_d   = 7'd0;
          presc_d = 16'd0;
        end
        default: begin
          state_d = S_IDLE;
          presc_d = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= 16'd0;
      out_q     <= 7'd0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      out_q     <= out_d;
      done_q    <= done_d;
      busy_q    <= (state_d == S_RUN);
      expired_q <= (state_d == S_DONE);
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule
